// File: rtl/cam_pkg.sv
// Shared widths, defaults and FSM state type for the camera pixel packer.
package cam_pkg;

    localparam int unsigned PIX_W        = 16;
    localparam int unsigned PIX_PER_WORD = 4;
    localparam int unsigned WORD_W       = 64;

    localparam int unsigned FRAME_WORDS_DEF = 76800;
    localparam logic [27:0] BASE_ADDR0_DEF  = 28'h0000000;
    localparam logic [27:0] BASE_ADDR1_DEF  = 28'h0096000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_FLUSH,
        ST_DRAIN,
        ST_DONE
    } pack_state_t;

endpackage

// File: rtl/cam_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; dout shows the head entry whenever !empty.
module cam_sync_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    output logic                     full,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    // A push into a full FIFO is taken when a pop frees the head slot in the same cycle.
    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != FULL_CNT) || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);
    assign count = count_q;

endmodule

// File: rtl/cam_pixel_packer.sv
// Packs RGB565 pixels four-per-word, queues words in a FWFT FIFO and writes them to DDR.
// Define CAM_PACK_PINGPONG_EN to alternate frames between BASE_ADDR0 and BASE_ADDR1.
module cam_pixel_packer
    import cam_pkg::*;
#(
    parameter int unsigned         FIFO_DEPTH  = 16,
    parameter int unsigned         ADDR_W      = 28,
    parameter int unsigned         FRAME_WORDS = FRAME_WORDS_DEF,
    parameter logic [ADDR_W-1:0]   BASE_ADDR0  = ADDR_W'(BASE_ADDR0_DEF),
    parameter logic [ADDR_W-1:0]   BASE_ADDR1  = ADDR_W'(BASE_ADDR1_DEF)
) (
    input  logic                camera_pclk,
    input  logic                rst_n,
    input  logic                pix_valid,
    input  logic [15:0]         pix_data,
    input  logic                frame_complete,
    output logic                fifo_ready,
    output logic                change_complete,
    output logic                wr_valid,
    input  logic                wr_ready,
    output logic [63:0]         wr_data,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic                wr_last,
    output logic                buf_sel,
    output logic                overflow,
    output logic                short_frame
);

    localparam int unsigned      IDX_W    = $clog2(FRAME_WORDS + 1);
    localparam int unsigned      LANE_W   = $clog2(PIX_PER_WORD);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_WORDS - 1);
    localparam logic [IDX_W-1:0] FULL_IDX = IDX_W'(FRAME_WORDS);

    pack_state_t                  state_q, state_d;
    logic [LANE_W-1:0]            lane_q, lane_d;
    logic [WORD_W-1:0]            pack_q, pack_d;
    logic [WORD_W-1:0]            push_word_q, push_word_d;
    logic                         push_q, push_d;
    logic [IDX_W-1:0]             word_idx_q, word_idx_d;
    logic                         overflow_q, overflow_d;
    logic                         short_q, short_d;
    logic                         buf_sel_q, buf_sel_d;

    logic                         fifo_full, fifo_empty, accept, take_pix;
    logic [WORD_W-1:0]            fifo_dout;
    logic [$clog2(FIFO_DEPTH):0]  fifo_count;
    logic [IDX_W-1:0]             addr_idx;

    cam_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (WORD_W)
    ) u_fifo (
        .clk   (camera_pclk),
        .rst_n (rst_n),
        .push  (push_q),
        .din   (push_word_q),
        .full  (fifo_full),
        .pop   (accept),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign wr_valid = !fifo_empty;
    assign accept   = wr_valid && wr_ready;
    assign take_pix = pix_valid && ((state_q == ST_IDLE) || (state_q == ST_CAPTURE));

    always_comb begin
        state_d     = state_q;
        lane_d      = lane_q;
        pack_d      = pack_q;
        push_d      = 1'b0;
        push_word_d = push_word_q;
        word_idx_d  = word_idx_q;
        overflow_d  = overflow_q;
        short_d     = short_q;
        buf_sel_d   = buf_sel_q;

        // pack_q is cleared after every push so unfilled lanes of a partial word read as zero.
        if (take_pix) begin
            pack_d[32'(lane_q)*PIX_W +: PIX_W] = pix_data;
            if (lane_q == LANE_W'(PIX_PER_WORD - 1)) begin
                push_d      = 1'b1;
                push_word_d = pack_d;
                pack_d      = '0;
                lane_d      = '0;
            end else begin
                lane_d = lane_q + 1'b1;
            end
        end

        if (push_q && fifo_full && !accept) begin
            overflow_d = 1'b1;
        end

        if (accept) begin
            if (word_idx_q == FULL_IDX) begin
                overflow_d = 1'b1;
            end else begin
                word_idx_d = word_idx_q + 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (pix_valid) state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (frame_complete) state_d = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (lane_q != '0) begin
                    push_d      = 1'b1;
                    push_word_d = pack_q;
                    pack_d      = '0;
                    lane_d      = '0;
                end
                state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if ((fifo_count == '0) && !push_q) begin
                    if (word_idx_q != FULL_IDX) short_d = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!frame_complete) begin
`ifdef CAM_PACK_PINGPONG_EN
                    buf_sel_d = !buf_sel_q;
`endif
                    word_idx_d = '0;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge camera_pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            lane_q      <= '0;
            pack_q      <= '0;
            push_word_q <= '0;
            push_q      <= 1'b0;
            word_idx_q  <= '0;
            overflow_q  <= 1'b0;
            short_q     <= 1'b0;
            buf_sel_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            lane_q      <= lane_d;
            pack_q      <= pack_d;
            push_word_q <= push_word_d;
            push_q      <= push_d;
            word_idx_q  <= word_idx_d;
            overflow_q  <= overflow_d;
            short_q     <= short_d;
            buf_sel_q   <= buf_sel_d;
        end
    end

    assign addr_idx        = (word_idx_q == FULL_IDX) ? LAST_IDX : word_idx_q;
    assign wr_addr         = (buf_sel_q ? BASE_ADDR1 : BASE_ADDR0) + (ADDR_W'(addr_idx) << 3);
    assign wr_data         = fifo_dout;
    assign wr_last         = wr_valid && (word_idx_q == LAST_IDX);
    assign fifo_ready      = (state_q == ST_IDLE);
    assign change_complete = (state_q == ST_DONE);
    assign buf_sel         = buf_sel_q;
    assign overflow        = overflow_q;
    assign short_frame     = short_q;

endmodule

// File: tb/tb_cam_pixel_packer.sv
// Scoreboard bench for cam_pixel_packer with a frame-level pixel/word reference model.
module tb_cam_pixel_packer;

    localparam int unsigned FW     = 24;
    localparam int unsigned ADDR_W = 28;
    localparam logic [27:0] BASE1  = 28'h0096000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pix_valid;
    logic [15:0] pix_data;
    logic        frame_complete;
    logic        fifo_ready;
    logic        change_complete;
    logic        wr_valid;
    logic        wr_ready;
    logic [63:0] wr_data;
    logic [27:0] wr_addr;
    logic        wr_last;
    logic        buf_sel;
    logic        overflow;
    logic        short_frame;

    always #5 clk = ~clk;

    cam_pixel_packer #(
        .FIFO_DEPTH  (16),
        .ADDR_W      (ADDR_W),
        .FRAME_WORDS (FW),
        .BASE_ADDR0  (28'h0000000),
        .BASE_ADDR1  (BASE1)
    ) dut (
        .camera_pclk     (clk),
        .rst_n           (rst_n),
        .pix_valid       (pix_valid),
        .pix_data        (pix_data),
        .frame_complete  (frame_complete),
        .fifo_ready      (fifo_ready),
        .change_complete (change_complete),
        .wr_valid        (wr_valid),
        .wr_ready        (wr_ready),
        .wr_data         (wr_data),
        .wr_addr         (wr_addr),
        .wr_last         (wr_last),
        .buf_sel         (buf_sel),
        .overflow        (overflow),
        .short_frame     (short_frame)
    );

    typedef struct packed {
        logic [63:0] data;
        logic [27:0] addr;
        logic        last;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // reference model state
    logic [15:0] acc[4];
    int          acc_n;
    int          widx;
    int          cap;
    logic        bsel_m, ovf_m, short_m;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_word();
        exp_t        e;
        logic [27:0] base;
        int          ai;
        if (widx >= cap) begin
            ovf_m = 1'b1;
        end else begin
            if (widx >= FW) ovf_m = 1'b1;
            ai     = (widx > FW - 1) ? FW - 1 : widx;
            base   = bsel_m ? BASE1 : 28'h0;
            e.data = {acc[3], acc[2], acc[1], acc[0]};
            e.addr = base + 28'(ai * 8);
            e.last = (widx == FW - 1);
            exp_q.push_back(e);
            widx++;
        end
        for (int k = 0; k < 4; k++) acc[k] = 16'h0;
        acc_n = 0;
    endtask

    task automatic model_pix(input logic [15:0] p);
        acc[acc_n] = p;
        acc_n++;
        if (acc_n == 4) model_word();
    endtask

    task automatic model_clear();
        exp_q.delete();
        for (int k = 0; k < 4; k++) acc[k] = 16'h0;
        acc_n   = 0;
        widx    = 0;
        bsel_m  = 1'b0;
        ovf_m   = 1'b0;
        short_m = 1'b0;
    endtask

    // The last pixel goes out together with frame_complete.
    task automatic send_pixels(input int n, input int pct, input bit seq);
        for (int i = 0; i < n; i++) begin
            while ($urandom_range(99) < 25) begin
                pix_valid = 1'b0;
                wr_ready  = ($urandom_range(99) < pct);
                step();
            end
            pix_valid      = 1'b1;
            pix_data       = seq ? 16'(i + 1) : 16'($urandom);
            frame_complete = (i == n - 1);
            model_pix(pix_data);
            if ((i == n - 1) && (acc_n != 0)) model_word();
            wr_ready = ($urandom_range(99) < pct);
            step();
        end
        pix_valid = 1'b0;
    endtask

    task automatic end_frame(input int pct);
        int cyc = 0;
        frame_complete = 1'b1;
        while ((change_complete !== 1'b1) && (cyc < 4000)) begin
            pix_valid = 1'($urandom_range(1));
            pix_data  = 16'($urandom);
            wr_ready  = ($urandom_range(99) < pct);
            step();
            cyc++;
        end
        pix_valid = 1'b0;
        if (widx < FW) short_m = 1'b1;
        chk("change_complete", 64'(change_complete), 64'd1);
        chk("short_frame", 64'(short_frame), 64'(short_m));
        chk("overflow", 64'(overflow), 64'(ovf_m));
        chk("fifo_ready_busy", 64'(fifo_ready), 64'd0);
        repeat (2) step();
        chk("done_hold", 64'(change_complete), 64'd1);
        frame_complete = 1'b0;
        step();
`ifdef CAM_PACK_PINGPONG_EN
        bsel_m = ~bsel_m;
`endif
        widx = 0;
        chk("fifo_ready_idle", 64'(fifo_ready), 64'd1);
        chk("change_complete_low", 64'(change_complete), 64'd0);
        chk("buf_sel", 64'(buf_sel), 64'(bsel_m));
    endtask

    // monitor: every accepted word is compared against the head of the scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && wr_valid && wr_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_word: got data %0h addr %0h, expected no word", wr_data, wr_addr);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_data", wr_data, e.data);
                    chk("wr_addr", 64'(wr_addr), 64'(e.addr));
                    chk("wr_last", 64'(wr_last), 64'(e.last));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; pix_valid = 1'b0; pix_data = 16'h0;
        frame_complete = 1'b0; wr_ready = 1'b0; cap = 1 << 30;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_fifo_ready", 64'(fifo_ready), 64'd1);
        chk("rst_wr_valid", 64'(wr_valid), 64'd0);
        chk("rst_change_complete", 64'(change_complete), 64'd0);
        chk("rst_wr_last", 64'(wr_last), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_short", 64'(short_frame), 64'd0);
        chk("rst_buf_sel", 64'(buf_sel), 64'd0);
        rst_n = 1'b1;
        step();

        // first word latency, then completion of a full frame
        wr_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            pix_valid = 1'b1;
            pix_data  = 16'(i);
            model_pix(pix_data);
            step();
        end
        pix_valid = 1'b0;
        chk("lat_edge_n", 64'(wr_valid), 64'd0);
        step();
        chk("lat_edge_n1", 64'(wr_valid), 64'd1);
        send_pixels(FW * 4 - 4, 80, 1'b0);
        end_frame(80);

        // short frame with a zero-filled partial word
        send_pixels(6, 100, 1'b1);
        end_frame(100);

        for (int f = 0; f < 6; f++) begin
            int pct;
            pct = 60 + int'($urandom_range(40));
            send_pixels(2 + int'($urandom_range(FW * 4 - 2)), pct, 1'b0);
            end_frame(pct);
        end

        // one word past the frame: saturated address, overflow
        send_pixels((FW + 1) * 4, 100, 1'b0);
        end_frame(100);

        // reset in the middle of a frame with words queued
        wr_ready = 1'b0;
        send_pixels(10, 0, 1'b0);
        frame_complete = 1'b0;
        repeat (3) step();
        chk("pre_rst_wr_valid", 64'(wr_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        model_clear();
        chk("midrst_wr_valid", 64'(wr_valid), 64'd0);
        chk("midrst_fifo_ready", 64'(fifo_ready), 64'd1);
        chk("midrst_overflow", 64'(overflow), 64'd0);
        chk("midrst_buf_sel", 64'(buf_sel), 64'd0);
        step();
        rst_n = 1'b1;
        step();

        // 17 words against a stalled sink: 16 kept, one dropped
        cap = 16;
        send_pixels(68, 0, 1'b0);
        pix_valid = 1'b0;
        wr_ready  = 1'b0;
        repeat (3) step();
        chk("stall_overflow", 64'(overflow), 64'd1);
        chk("stall_wr_valid", 64'(wr_valid), 64'd1);
        end_frame(100);
        cap = 1 << 30;

        send_pixels(9, 90, 1'b0);
        end_frame(90);

        repeat (5) step();
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
